ce_relu_maxpool: RTL and testbench
==================================

CE_RELU_MAXPOOL -- requirements
Module: ce_relu_maxpool

Interface
REQ-001 Parameter N, default 2: output data width; equals the CE input data width.
REQ-002 Parameter M, default 2: CE weight width; used only to size d_in.
REQ-003 Parameter EXT, default 15: CE result extension bits; d_in width W = N+M+EXT.
REQ-004 Parameter SR, default 2: arithmetic right shift applied before saturation.
REQ-005 Parameter RELU, default 1: 1 means clamp negatives to 0 and output unsigned; 0 means output signed.
REQ-006 Parameter IMG_W, default 8: conv results per row; even, 2..1024.
REQ-007 Parameter IMG_H, default 8: conv rows per frame; even, 2..1024.
REQ-008 clk  in  1  clock; all state updates on the rising edge.
REQ-009 rst  in  1  reset rst, synchronous, active-high.
REQ-010 d_in  in  W  CE conv result, two's complement, raster order.
REQ-011 en_in  in  1  d_in valid strobe; may be asserted every cycle or with arbitrary gaps.
REQ-012 d_out  out  N  pooled, quantized feature value.
REQ-013 en_out  out  1  single-cycle d_out valid strobe.
REQ-014 frame_done  out  1  single-cycle pulse, coincident with the last en_out of a frame.

Function
REQ-015 Stage Q (registered, 1 cycle): x = d_in >>> SR (sign-preserving).
REQ-016 Stage Q, RELU=1: x<0 gives 0; x>2^N-1 gives 2^N-1; otherwise x.
REQ-017 Stage Q, RELU=0: saturate x to [-2^(N-1), 2^(N-1)-1].
REQ-018 Stage Q shall forward en_in as a valid bit q_vld; q_vld gates every pooling action.
REQ-019 col counter shall advance 0..IMG_W-1 on each q_vld and wrap to 0.
REQ-020 row counter shall advance 0..IMG_H-1 on the col wrap and wrap to 0 at end of frame.
REQ-021 Horizontal pair, even col: hold q in register h.
REQ-022 Horizontal pair, odd col: compute p = max(h, q).
REQ-023 Comparisons shall be unsigned when RELU=1 and signed when RELU=0.
REQ-024 Even row, odd col: write p into line buffer lb[col/2]; depth IMG_W/2, width N.
REQ-025 Odd row, odd col: d_out <= max(lb[col/2], p) and en_out <= 1 on the same edge.
REQ-026 Latency: en_out shall rise exactly 2 cycles after the en_in of the odd-row, odd-col sample.
REQ-027 en_out shall be 0 in every cycle that is not an output cycle; d_out shall hold its last value.
REQ-028 Output count: exactly (IMG_W/2)*(IMG_H/2) en_out pulses per frame.
REQ-029 frame_done shall assert with the en_out for row IMG_H-1, col IMG_W-1.
REQ-030 The next frame shall begin on the next q_vld after frame_done with no idle cycle required.
REQ-031 Gaps in en_in shall not alter counters, h or lb; the output depends only on the sample sequence.
REQ-032 The line buffer shall support a read and a write to different addresses in one cycle.

Reset
REQ-033 On rst, the following shall clear to 0: d_out, en_out, frame_done, q_vld, col, row and h.
REQ-034 The lb contents are not reset; every entry is written before it is read.
REQ-035 rst asserted mid-frame shall abandon the partial frame; the first q_vld after reset shall be treated as row 0, col 0.
REQ-036 An en_in sampled in the same cycle as rst shall be discarded.

Structure
REQ-037 Shared package cnn_pkg shall hold EXT=15 and the constant functions clog2 and max_signed/max_unsigned.
REQ-038 The counter widths shall be clog2(IMG_W) and clog2(IMG_H).
REQ-039 The quantizer (shift, ReLU, saturate) shall be sub-module ce_quant, so it can be reused in front of non-pooled layers.
REQ-040 The line buffer shall be an inferred register array inside ce_relu_maxpool.

Verification
All scenarios use N=2, M=2, SR=2, IMG_W=4, IMG_H=4 unless a scenario states otherwise.
REQ-041 Quantize: single inputs 13, 100 and -8 with RELU=1 -> 3, 3 and 0; input -8 with RELU=0 -> -2 (binary 10).
REQ-042 Frame, back-to-back inputs:
- row0 = 0,4,0,0
- row1 = 0,0,8,12
- rows 2 and 3 all 0
- required: en_out with d_out=1, then en_out with d_out=3 (2 cycles after the 8th input), then 0, then 0 with frame_done.
REQ-043 Same frame with random 0-3 cycle gaps between en_in -> identical d_out sequence; each en_out exactly 2 cycles after its triggering en_in.
REQ-044 Two consecutive frames with no gap -> 8 en_out pulses and 2 frame_done pulses; the second frame is unaffected by the first frame's lb contents.
REQ-045 rst asserted after 6 inputs, then a full frame -> exactly 4 en_out pulses, values matching a clean frame.
REQ-046 RELU=0 frame with inputs -8 and -4 (quantized -2 and -1) in one pool window -> d_out = -1 (signed max).

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and constant functions for the CE post-processing blocks.
package cnn_pkg;

    // Extra result bits the CE accumulator carries beyond data + weight width.
    localparam int EXT = 15;

    // Bits needed to count 0..value-1; never returns less than 1 so that
    // degenerate sizes still give a legal vector width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Largest value representable in n bits, two's complement.
    function automatic int max_signed(input int n);
        return (1 << (n - 1)) - 1;
    endfunction

    // Largest value representable in n bits, unsigned.
    function automatic int max_unsigned(input int n);
        return (1 << n) - 1;
    endfunction

endpackage

// File: rtl/ce_quant.sv
// Quantizer: arithmetic right shift, optional ReLU, saturation to N bits.
// One register stage; the input strobe is forwarded alongside the data.
module ce_quant #(
    parameter int N    = 2,
    parameter int W    = 19,
    parameter int SR   = 2,
    parameter int RELU = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_in_i,
    input  logic         en_in_i,
    output logic [N-1:0] q_o,
    output logic         q_vld_o
);
    import cnn_pkg::*;

    localparam logic signed [W-1:0] U_MAX = W'(max_unsigned(N));
    localparam logic signed [W-1:0] S_MAX = W'(max_signed(N));
    localparam logic signed [W-1:0] S_MIN = W'(-max_signed(N) - 1);

    logic signed [W-1:0] x;
    logic [N-1:0]        q_d, q_q;
    logic                q_vld_q;

    // Shift, then clamp into the output range of the selected mode.
    always_comb begin
        // NOTE: q_d is given a default before any branch so no path leaves it
        // unassigned; an incomplete assignment here would infer a latch.
        x   = $signed(d_in_i) >>> SR;
        q_d = x[N-1:0];
        if (RELU != 0) begin
            if (x[W-1])
                q_d = '0;
            else if (x > U_MAX)
                q_d = U_MAX[N-1:0];
        end else begin
            if (x > S_MAX)
                q_d = S_MAX[N-1:0];
            else if (x < S_MIN)
                q_d = S_MIN[N-1:0];
        end
    end

    // Register the quantized value and its valid bit; a strobe seen during reset is dropped.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with <= so every flop samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            q_q     <= '0;
            q_vld_q <= 1'b0;
        end else begin
            q_vld_q <= en_in_i;
            if (en_in_i)
                q_q <= q_d;
        end
    end

    assign q_o     = q_q;
    assign q_vld_o = q_vld_q;

endmodule

// File: rtl/ce_relu_maxpool.sv
// Quantize CE conv results and 2x2 max-pool them over a raster-order frame.
// A horizontal pair is reduced in register h, the even-row pair result is
// parked in a half-row line buffer and combined with the odd-row pair.
module ce_relu_maxpool #(
    parameter int N     = 2,
    parameter int M     = 2,
    parameter int EXT   = 15,
    parameter int SR    = 2,
    parameter int RELU  = 1,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N+M+EXT-1:0] d_in,
    input  logic               en_in,
    output logic [N-1:0]       d_out,
    output logic               en_out,
    output logic               frame_done
);
    import cnn_pkg::*;

    localparam int W    = N + M + EXT;
    localparam int CW   = clog2(IMG_W);
    localparam int RW   = clog2(IMG_H);
    localparam int LB_D = IMG_W / 2;
    localparam int AW   = clog2(LB_D);

    logic [N-1:0]  q;
    logic          q_vld;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [N-1:0]  h_q, h_d;
    logic [N-1:0]  d_out_q, d_out_d;
    logic          en_out_q, en_out_d;
    logic          fd_q, fd_d;
    logic [N-1:0]  lb [LB_D];
    logic [AW-1:0] lb_addr;
    logic          lb_we;
    logic [N-1:0]  p, pool;
    logic          col_last, row_last;

    // Max in the numeric domain of the output: unsigned after ReLU, signed otherwise.
    function automatic logic [N-1:0] max2(input logic [N-1:0] a, input logic [N-1:0] b);
        if (RELU != 0)
            return (a > b) ? a : b;
        else
            return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    ce_quant #(
        .N    (N),
        .W    (W),
        .SR   (SR),
        .RELU (RELU)
    ) u_quant (
        .clk     (clk),
        .rst     (rst),
        .d_in_i  (d_in),
        .en_in_i (en_in),
        .q_o     (q),
        .q_vld_o (q_vld)
    );

    // Raster position bookkeeping and the pooling decision for the current sample.
    always_comb begin
        col_last = (col_q == CW'(IMG_W - 1));
        row_last = (row_q == RW'(IMG_H - 1));
        lb_addr  = AW'(col_q >> 1);
        p        = max2(h_q, q);
        pool     = max2(lb[lb_addr], p);

        col_d    = col_q;
        row_d    = row_q;
        h_d      = h_q;
        d_out_d  = d_out_q;
        en_out_d = 1'b0;
        fd_d     = 1'b0;
        lb_we    = 1'b0;

        if (q_vld) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last)
                row_d = row_last ? '0 : row_q + 1'b1;

            if (!col_q[0]) begin
                h_d = q;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                d_out_d  = pool;
                en_out_d = 1'b1;
                fd_d     = row_last && col_last;
            end
        end
    end

    // Counters, pair register and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            h_q      <= '0;
            d_out_q  <= '0;
            en_out_q <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            h_q      <= h_d;
            d_out_q  <= d_out_d;
            en_out_q <= en_out_d;
            fd_q     <= fd_d;
        end
    end

    // Line buffer write of the even-row pair maximum.
    always_ff @(posedge clk) begin
        // NOTE: the line buffer has no reset; each entry is written on an even
        // row before the odd row reads it, so its power-up value never matters.
        if (lb_we && !rst)
            lb[lb_addr] <= p;
    end

    assign d_out      = d_out_q;
    assign en_out     = en_out_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_ce_relu_maxpool.sv
// Scoreboard bench: two DUTs (RELU=1 and RELU=0) share one stimulus stream;
// a frame-level reference model pushes expected pool results, monitors pop them.
module tb_ce_relu_maxpool;

    localparam int N     = 2;
    localparam int M     = 2;
    localparam int EXT   = 15;
    localparam int SR    = 2;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int W     = N + M + EXT;
    localparam int NPIX  = IMG_W * IMG_H;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] d_in;
    logic         en_in;
    logic [N-1:0] d_out1, d_out0;
    logic         en_out1, en_out0, fd1, fd0;

    typedef struct {
        logic [N-1:0] d;
        logic         fd;
        int           cyc;
    } exp_t;

    exp_t         q1[$];
    exp_t         q0[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           n_out[2];
    int           n_fd[2];
    logic [N-1:0] last_d[2];
    logic         rst_prev = 1'b1;
    logic         mon_en = 1'b0;
    int           pix[NPIX];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ce_relu_maxpool #(
        .N(N), .M(M), .EXT(EXT), .SR(SR), .RELU(1), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) u_dut_relu (
        .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in),
        .d_out(d_out1), .en_out(en_out1), .frame_done(fd1)
    );

    ce_relu_maxpool #(
        .N(N), .M(M), .EXT(EXT), .SR(SR), .RELU(0), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) u_dut_signed (
        .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in),
        .d_out(d_out0), .en_out(en_out0), .frame_done(fd0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference quantizer from the arithmetic rules: shift by SR, then clamp.
    function automatic int quant(input int x, input bit relu);
        int s;
        s = x >>> SR;
        if (relu) begin
            if (s < 0) return 0;
            if (s > (1 << N) - 1) return (1 << N) - 1;
            return s;
        end
        if (s > (1 << (N - 1)) - 1) return (1 << (N - 1)) - 1;
        if (s < -(1 << (N - 1))) return -(1 << (N - 1));
        return s;
    endfunction

    // Maximum over the quantized 2x2 window (wr, wc) of the current frame.
    function automatic int window_max(input int wr, input int wc, input bit relu);
        int m;
        m = quant(pix[(2 * wr) * IMG_W + 2 * wc], relu);
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
                int v;
                v = quant(pix[(2 * wr + dr) * IMG_W + 2 * wc + dc], relu);
                if (v > m) m = v;
            end
        return m;
    endfunction

    task automatic monitor_one(input int k, input logic en, input logic [N-1:0] d, input logic fd);
        exp_t e;
        if (en === 1'b1) begin
            n_out[k]++;
            if (fd === 1'b1) n_fd[k]++;
            if ((k == 1 && q1.size() == 0) || (k == 0 && q0.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL dut%0d_unexpected_out: got d_out=%0d with nothing expected (t=%0t)", k, d, $time);
            end else begin
                e = (k == 1) ? q1.pop_front() : q0.pop_front();
                check($sformatf("dut%0d_d_out", k), 32'(d), 32'(e.d));
                check($sformatf("dut%0d_frame_done", k), 32'(fd), 32'(e.fd));
                check($sformatf("dut%0d_latency_cycle", k), cyc, e.cyc);
            end
        end else begin
            check($sformatf("dut%0d_en_out_idle", k), 32'(en), 32'(0));
            check($sformatf("dut%0d_frame_done_idle", k), 32'(fd), 32'(0));
            if (!rst_prev)
                check($sformatf("dut%0d_d_out_hold", k), 32'(d), 32'(last_d[k]));
        end
        last_d[k] = d;
    endtask

    // Monitor: sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            monitor_one(1, en_out1, d_out1, fd1);
            monitor_one(0, en_out0, d_out0, fd0);
            rst_prev = rst;
        end
    end

    task automatic drive_idle();
        en_in = 1'b0;
        d_in  = W'($urandom);
        @(posedge clk);
        #1;
    endtask

    // Drive pix[] as one frame; abort_after >= 0 asserts rst in place of that sample.
    task automatic run_frame(input int max_gap, input int abort_after);
        int e1[4];
        int e0[4];
        for (int w = 0; w < 4; w++) begin
            e1[w] = window_max(w / 2, w % 2, 1'b1);
            e0[w] = window_max(w / 2, w % 2, 1'b0);
        end
        for (int i = 0; i < NPIX; i++) begin
            int r;
            int c;
            r = i / IMG_W;
            c = i % IMG_W;
            repeat ($urandom_range(0, max_gap)) drive_idle();
            if (i == abort_after) begin
                rst   = 1'b1;
                en_in = 1'b1;
                d_in  = W'(100);
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                rst   = 1'b0;
                en_in = 1'b0;
                return;
            end
            en_in = 1'b1;
            d_in  = W'(pix[i]);
            if (abort_after < 0 && (r % 2) == 1 && (c % 2) == 1) begin
                int w;
                exp_t e;
                w     = (r / 2) * 2 + (c / 2);
                e.cyc = cyc + 2;
                e.fd  = (i == NPIX - 1);
                e.d   = N'(e1[w]);
                q1.push_back(e);
                e.d   = N'(e0[w]);
                q0.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        en_in = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q1.size() != 0 || q0.size() != 0) && k < 20) begin
            drive_idle();
            k++;
        end
        check("drain_pending", q1.size() + q0.size(), 0);
    endtask

    task automatic load_directed();
        for (int i = 0; i < NPIX; i++) pix[i] = 0;
        pix[1] = 4;
        pix[6] = 8;
        pix[7] = 12;
    endtask

    task automatic load_random();
        for (int i = 0; i < NPIX; i++)
            if ($urandom_range(0, 3) == 0)
                pix[i] = int'($urandom_range(0, 127)) - 64;
            else
                pix[i] = int'($urandom_range(0, 31)) - 16;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s_out[2];
        int s_fd[2];
        n_out = '{0, 0};
        n_fd  = '{0, 0};
        last_d = '{'0, '0};

        // Reset with a strobe present; that strobe must not count as a sample.
        rst   = 1'b1;
        en_in = 1'b1;
        d_in  = W'(100);
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_d_out_relu", 32'(d_out1), 0);
        check("rst_d_out_signed", 32'(d_out0), 0);
        check("rst_frame_done", 32'({fd1, fd0}), 0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        en_in = 1'b0;
        drive_idle();

        // Directed frame, back-to-back, then the same frame with gaps.
        load_directed();
        run_frame(0, -1);
        drain();
        run_frame(3, -1);
        drain();

        // Quantizer corners and signed max within one window.
        for (int i = 0; i < NPIX; i++) pix[i] = -8;
        pix[0] = 13;  pix[1] = 13;  pix[4] = 13;  pix[5] = 13;
        pix[2] = 100; pix[3] = 0;   pix[6] = 0;   pix[7] = 0;
        pix[11] = -4;
        run_frame(1, -1);
        drain();

        // Two frames with no gap between them.
        s_out = n_out;
        s_fd  = n_fd;
        load_random();
        run_frame(0, -1);
        load_random();
        run_frame(0, -1);
        drain();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d_two_frames_out", k), n_out[k] - s_out[k], 8);
            check($sformatf("dut%0d_two_frames_done", k), n_fd[k] - s_fd[k], 2);
        end

        // Reset after six samples, then a clean frame.
        s_out = n_out;
        load_directed();
        run_frame(0, 6);
        run_frame(0, -1);
        drain();
        for (int k = 0; k < 2; k++)
            check($sformatf("dut%0d_after_abort_out", k), n_out[k] - s_out[k], 4);

        // Random frames with random gaps.
        repeat (8) begin
            load_random();
            run_frame(3, -1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
